// File: rtl/neopixel_frame_builder_if.sv
// rtl/neopixel_frame_builder_if.sv - pixel write, fill, commit and framebuf bundle for neopixel_frame_builder
interface neopixel_frame_builder_if #(
    parameter int NUM_PIXELS = 16,
    parameter int IDX_W      = 4,
    parameter int FB_W       = 24 * NUM_PIXELS
);
    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_index;
    logic [23:0]      wr_rgb;
    logic             fill_req;
    logic [23:0]      fill_rgb;
    logic             commit_req;
    logic [7:0]       brightness;
    logic             busy;
    logic             commit_done;
    logic [FB_W-1:0]  framebuf;

    modport master (
        output wr_valid, wr_index, wr_rgb, fill_req, fill_rgb, commit_req, brightness,
        input  wr_ready, busy, commit_done, framebuf
    );

    modport slave (
        input  wr_valid, wr_index, wr_rgb, fill_req, fill_rgb, commit_req, brightness,
        output wr_ready, busy, commit_done, framebuf
    );
endinterface

// File: rtl/neopixel_frame_builder.sv
// rtl/neopixel_frame_builder.sv - shadow/active pixel buffer with atomic commit feeding the neopixel serialiser
// Optional feature macro: BRIGHTNESS_EN (global per-channel brightness scaling at write acceptance).
module neopixel_frame_builder #(
    parameter int NUM_PIXELS = 16,
    parameter int IDX_W      = 4,
    parameter int FB_W       = 24 * NUM_PIXELS
) (
    input  logic                     clk,
    input  logic                     rst,
    neopixel_frame_builder_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [23:0]      fill_q, fill_d;
    logic             stg_vld_q, stg_vld_d;
    logic [IDX_W-1:0] stg_idx_q, stg_idx_d;
    logic [23:0]      stg_rgb_q, stg_rgb_d;
    logic [FB_W-1:0]  shadow_q, shadow_d;
    logic [FB_W-1:0]  active_q, active_d;
    logic             done_q, done_d;
    logic [23:0]      wr_scaled, fill_scaled;
    logic             accept;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Pixel word as the serialiser wants it: bytes G,R,B from the low end, each LSB-first.
    function automatic logic [23:0] to_wire(input logic [23:0] rgb);
        return {rev8(rgb[7:0]), rev8(rgb[23:16]), rev8(rgb[15:8])};
    endfunction

`ifdef BRIGHTNESS_EN
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [23:0] scale(input logic [23:0] rgb, input logic [7:0] b);
        return {scale8(rgb[23:16], b), scale8(rgb[15:8], b), scale8(rgb[7:0], b)};
    endfunction

    assign wr_scaled   = scale(bus.wr_rgb, bus.brightness);
    assign fill_scaled = scale(bus.fill_rgb, bus.brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^bus.brightness;
    assign wr_scaled   = bus.wr_rgb;
    assign fill_scaled = bus.fill_rgb;
`endif

    assign accept = bus.wr_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        fill_d    = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.fill_req) begin
                    state_d   = ST_FILL;
                    cnt_d     = '0;
                    pending_d = bus.commit_req;
                    fill_d    = fill_scaled;
                end else if (bus.commit_req) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.commit_req) pending_d = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = (pending_q || bus.commit_req) ? ST_COMMIT : ST_IDLE;
                end
            end
            ST_COMMIT: begin
                pending_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fill traffic owns the stage while filling; client writes can only land in IDLE.
    always_comb begin
        stg_vld_d = 1'b0;
        stg_idx_d = stg_idx_q;
        stg_rgb_d = stg_rgb_q;
        if (state_q == ST_FILL) begin
            stg_vld_d = 1'b1;
            stg_idx_d = cnt_q;
            stg_rgb_d = fill_q;
        end else if (accept) begin
            stg_vld_d = 1'b1;
            stg_idx_d = bus.wr_index;
            stg_rgb_d = wr_scaled;
        end
    end

    // Out-of-range indices match no pixel slot and simply retire without effect.
    always_comb begin
        shadow_d = shadow_q;
        for (int p = 0; p < NUM_PIXELS; p++) begin
            if (stg_vld_q && (stg_idx_q == IDX_W'(p)))
                shadow_d[24*p +: 24] = to_wire(stg_rgb_q);
        end
    end

    assign active_d = (state_q == ST_COMMIT) ? shadow_d : active_q;
    assign done_d   = (state_q == ST_COMMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            fill_q    <= '0;
            stg_vld_q <= 1'b0;
            stg_idx_q <= '0;
            stg_rgb_q <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            fill_q    <= fill_d;
            stg_vld_q <= stg_vld_d;
            stg_idx_q <= stg_idx_d;
            stg_rgb_q <= stg_rgb_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign bus.wr_ready    = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE) || pending_q;
    assign bus.commit_done = done_q;
    assign bus.framebuf    = active_q;
endmodule

// File: tb/tb_neopixel_frame_builder.sv
// tb/tb_neopixel_frame_builder.sv - directed self-checking bench for neopixel_frame_builder
module tb_neopixel_frame_builder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [383:0] exp_fb;

    always #5 clk = ~clk;

    neopixel_frame_builder_if #(.NUM_PIXELS(16), .IDX_W(4)) bus ();
    neopixel_frame_builder_if #(.NUM_PIXELS(12), .IDX_W(4)) bus12 ();

    neopixel_frame_builder #(.NUM_PIXELS(16), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    neopixel_frame_builder #(.NUM_PIXELS(12), .IDX_W(4)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12.slave)
    );

    task automatic idle_inputs();
        bus.wr_valid = 0; bus.wr_index = 0; bus.wr_rgb = 0;
        bus.fill_req = 0; bus.fill_rgb = 0; bus.commit_req = 0; bus.brightness = 8'hFF;
        bus12.wr_valid = 0; bus12.wr_index = 0; bus12.wr_rgb = 0;
        bus12.fill_req = 0; bus12.fill_rgb = 0; bus12.commit_req = 0; bus12.brightness = 8'hFF;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [23:0] rgb);
        bus.wr_valid = 1; bus.wr_index = idx; bus.wr_rgb = rgb;
        @(negedge clk);
        bus.wr_valid = 0;
    endtask

    // Returns the number of rising edges from the request edge to commit_done, 99 on timeout.
    task automatic do_commit(output int lat);
        bus.commit_req = 1;
        @(negedge clk);
        bus.commit_req = 0;
        lat = 0;
        while (bus.commit_done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (bus.commit_done !== 1'b1) lat = 99;
    endtask

    task automatic check_pulse_ends(input string name);
        @(negedge clk);
        checks++;
        if (bus.commit_done !== 1'b0) begin
            errors++;
            $display("FAIL %s commit_done still high after one cycle", name);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.framebuf !== 384'd0 || bus.busy !== 1'b0 || bus.commit_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs fb=%h busy=%b done=%b want 0/0/0", bus.framebuf, bus.busy, bus.commit_done);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready);
        end
    endtask

    task automatic test_write_commit();
        int lat;
        do_write(4'd0, 24'h800100);
        do_commit(lat);
        exp_fb = 384'd0;
        exp_fb[23:0] = 24'h000180;
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL commit_latency got %0d want 1", lat);
        end
        checks++;
        if (bus.framebuf !== exp_fb) begin
            errors++;
            $display("FAIL write_commit fb=%h want %h", bus.framebuf, exp_fb);
        end
        check_pulse_ends("write_commit_pulse");
    endtask

    task automatic test_hold_until_commit();
        int bad = 0;
        int lat;
        do_write(4'd5, 24'h123456);
        for (int i = 0; i < 100; i++) begin
            if (bus.framebuf !== exp_fb || bus.commit_done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable got %0d changed cycles want 0", bad);
        end
        do_commit(lat);
        exp_fb[143:120] = 24'h6A482C;
        checks++;
        if (bus.framebuf !== exp_fb) begin
            errors++;
            $display("FAIL idx5_commit fb=%h want %h", bus.framebuf, exp_fb);
        end
        check_pulse_ends("idx5_pulse");
    endtask

    task automatic test_fill();
        int n = 0;
        int lat;
        bus.fill_req = 1; bus.fill_rgb = 24'hFFFFFF;
        @(negedge clk);
        bus.fill_req = 0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_busy got %b want 1", bus.busy);
        end
        while (bus.wr_ready === 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL fill_not_ready_cycles got %0d want 16", n);
        end
        checks++;
        if (bus.framebuf !== exp_fb) begin
            errors++;
            $display("FAIL fill_no_commit fb=%h want %h", bus.framebuf, exp_fb);
        end
        do_commit(lat);
        exp_fb = {384{1'b1}};
        checks++;
        if (bus.framebuf !== exp_fb) begin
            errors++;
            $display("FAIL fill_commit fb=%h want all ones", bus.framebuf);
        end
        check_pulse_ends("fill_pulse");
    endtask

    task automatic test_fill_and_commit();
        int n = 0;
        int torn = 0;
        bus.fill_req = 1; bus.commit_req = 1; bus.fill_rgb = 24'h0F0000;
        @(negedge clk);
        bus.fill_req = 0; bus.commit_req = 0;
        while (bus.commit_done !== 1'b1 && n < 40) begin
            if (bus.framebuf !== exp_fb) torn++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL fill_commit_latency got %0d want 17", n);
        end
        checks++;
        if (torn != 0) begin
            errors++;
            $display("FAIL fill_commit_torn got %0d early changes want 0", torn);
        end
        exp_fb = {16{24'h00F000}};
        checks++;
        if (bus.framebuf !== exp_fb) begin
            errors++;
            $display("FAIL fill_commit_frame fb=%h want %h", bus.framebuf, exp_fb);
        end
        check_pulse_ends("fill_commit_pulse");
    endtask

    task automatic test_write_with_commit();
        int n = 0;
        bus.wr_valid = 1; bus.wr_index = 4'd15; bus.wr_rgb = 24'hA5C3E1; bus.commit_req = 1;
        @(negedge clk);
        bus.wr_valid = 0; bus.commit_req = 0;
        while (bus.commit_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp_fb[383:360] = 24'h87A5C3;
        checks++;
        if (n != 1 || bus.framebuf !== exp_fb) begin
            errors++;
            $display("FAIL write_with_commit lat=%0d fb=%h want lat 1 fb %h", n, bus.framebuf, exp_fb);
        end
        check_pulse_ends("write_with_commit_pulse");
    endtask

    task automatic test_index_drop();
        int n = 0;
        logic [287:0] exp12;
        bus12.wr_valid = 1; bus12.wr_index = 4'd11; bus12.wr_rgb = 24'h010203;
        @(negedge clk);
        bus12.wr_index = 4'd12; bus12.wr_rgb = 24'hFFFFFF;
        @(negedge clk);
        bus12.wr_valid = 0; bus12.commit_req = 1;
        @(negedge clk);
        bus12.commit_req = 0;
        while (bus12.commit_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp12 = 288'd0;
        exp12[287:264] = 24'hC08040;
        checks++;
        if (n != 1 || bus12.framebuf !== exp12) begin
            errors++;
            $display("FAIL index_drop lat=%0d fb=%h want lat 1 fb %h", n, bus12.framebuf, exp12);
        end
        checks++;
        if (bus12.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL index_drop_ready got %b want 1", bus12.wr_ready);
        end
    endtask

    task automatic test_brightness();
        int lat;
        bus.brightness = 8'h7F;
        do_write(4'd1, 24'h80FF40);
        bus.brightness = 8'hFF;
        do_commit(lat);
`ifdef BRIGHTNESS_EN
        exp_fb[47:24] = 24'h0402FE;
`else
        exp_fb[47:24] = 24'h0201FF;
`endif
        checks++;
        if (bus.framebuf !== exp_fb) begin
            errors++;
            $display("FAIL brightness fb=%h want %h", bus.framebuf, exp_fb);
        end
    endtask

    task automatic test_reset_mid_fill();
        int lat;
        bus.fill_req = 1; bus.fill_rgb = 24'h123456;
        @(negedge clk);
        bus.fill_req = 0;
        repeat (5) @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if (bus.framebuf !== 384'd0 || bus.busy !== 1'b0 || bus.commit_done !== 1'b0 || bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_fill fb=%h busy=%b done=%b ready=%b want 0/0/0/1",
                     bus.framebuf, bus.busy, bus.commit_done, bus.wr_ready);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        do_commit(lat);
        checks++;
        if (lat != 1 || bus.framebuf !== 384'd0) begin
            errors++;
            $display("FAIL reset_no_partial lat=%0d fb=%h want lat 1 fb 0", lat, bus.framebuf);
        end
    endtask

    initial begin
        idle_inputs();
        exp_fb = 384'd0;
        test_reset();
        test_write_commit();
        test_hold_until_commit();
        test_fill();
        test_fill_and_commit();
        test_write_with_commit();
        test_index_drop();
        test_brightness();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
